// File: rtl/pixel_buffer_reader_if.sv
// Bus bundle for the frame scan-out stage.
// Carries the RAM port-2 read master signals and the Avalon-ST video source.
// The reader takes the master view; the RAM/sink side takes the slave view.
interface pixel_buffer_reader_if #(
  parameter int DW = 8,
  parameter int AW = 19
);
  logic [AW-1:0] ram_address;
  logic          ram_chipselect;
  logic          ram_clken;
  logic          ram_write;
  logic [DW-1:0] ram_writedata;
  logic [DW-1:0] ram_readdata;
  logic [DW-1:0] st_data;
  logic          st_valid;
  logic          st_ready;
  logic          st_sop;
  logic          st_eop;

  modport master (
    output ram_address, ram_chipselect, ram_clken, ram_write, ram_writedata,
    input  ram_readdata,
    output st_data, st_valid, st_sop, st_eop,
    input  st_ready
  );

  modport slave (
    input  ram_address, ram_chipselect, ram_clken, ram_write, ram_writedata,
    output ram_readdata,
    input  st_data, st_valid, st_sop, st_eop,
    output st_ready
  );
endinterface

// File: rtl/pixel_buffer_reader.sv
// Frame scan-out: reads the pixel RAM sequentially through port 2 and emits
// the pixels as an Avalon-ST stream with SOP on pixel 0 and EOP on the last
// pixel. A small show-ahead FIFO soaks up the one-cycle RAM latency and sink
// backpressure; a credit check (fill + in-flight < depth) keeps it from overflowing.
module pixel_buffer_reader #(
  parameter int H_RES      = 640,
  parameter int V_RES      = 480,
  parameter int DW         = 8,
  parameter int AW         = 19,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  enable,
  pixel_buffer_reader_if.master bus,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int              NPIX     = H_RES * V_RES;
  localparam logic [AW-1:0]   LAST_IDX = AW'(NPIX - 1);
  localparam int              PW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int              CW       = PW + 1;
  localparam logic [CW-1:0]   DEPTH_C  = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nxt;

  logic [AW-1:0] pix_idx;
  logic          issue;
  logic          inflight;
  logic          inflight_sop;
  logic          inflight_eop;

  logic [DW+1:0] fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] fifo_count;
  logic          fifo_empty;
  logic          push;
  logic          pop;
  logic [DW+1:0] head;

  assign fifo_empty = (fifo_count == '0);
  assign head       = fifo_mem[rd_ptr];
  assign push       = inflight;
  assign pop        = !fifo_empty && bus.st_ready;
  assign issue      = (state == FETCH) && ((fifo_count + CW'(inflight)) < DEPTH_C);

  assign bus.ram_address    = pix_idx;
  assign bus.ram_chipselect = issue;
  assign bus.ram_clken      = issue;
  assign bus.ram_write      = 1'b0;
  assign bus.ram_writedata  = '0;

  assign bus.st_valid = !fifo_empty;
  assign bus.st_data  = fifo_empty ? '0 : head[DW+1:2];
  assign bus.st_sop   = !fifo_empty && head[1];
  assign bus.st_eop   = !fifo_empty && head[0];
  assign busy         = (state != IDLE);

  // State register for the fetch/drain sequencer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state: fetch a whole frame, then wait for its EOP to be taken before restarting or idling.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (enable) state_nxt = FETCH;
      FETCH:   if (issue && (pix_idx == LAST_IDX)) state_nxt = DRAIN;
      DRAIN:   if (frame_done) state_nxt = enable ? FETCH : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Pixel index, plus the tag of the read whose data returns next cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pix_idx      <= '0;
      inflight     <= 1'b0;
      inflight_sop <= 1'b0;
      inflight_eop <= 1'b0;
    end else begin
      inflight <= issue;
      if (issue) begin
        inflight_sop <= (pix_idx == '0);
        inflight_eop <= (pix_idx == LAST_IDX);
        pix_idx      <= (pix_idx == LAST_IDX) ? '0 : pix_idx + AW'(1);
      end
    end
  end

  // FIFO pointers and fill level; simultaneous push and pop leaves the level unchanged.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // FIFO storage: returned RAM data with its SOP/EOP tag.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= {bus.ram_readdata, inflight_sop, inflight_eop};
  end

  // One-cycle pulse after the sink takes the EOP pixel.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_done <= 1'b0;
    end else begin
      frame_done <= pop && head[0];
    end
  end

endmodule

// File: tb/tb_pixel_buffer_reader.sv
// Bench for pixel_buffer_reader on a 4x3 frame with RAM[i]=i.
// A scoreboard queue holds the expected pixel stream; a monitor pops and
// compares on each accepted beat, and also checks frame_done timing,
// hold stability under backpressure and RAM address range.
module tb_pixel_buffer_reader;

  localparam int H_RES      = 4;
  localparam int V_RES      = 3;
  localparam int DW         = 8;
  localparam int AW         = 19;
  localparam int FIFO_DEPTH = 4;
  localparam int NPIX       = H_RES * V_RES;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          sop;
    logic          eop;
  } exp_t;

  typedef struct {
    string name;
    int    ready_mode;
    int    frames;
    int    drop_after;
    int    exp_pixels;
    int    exp_sop;
    int    exp_eop;
    int    exp_done;
  } vec_t;

  logic clk = 1'b0;
  logic reset_n;
  logic enable;
  logic busy;
  logic frame_done;

  int tests_run    = 0;
  int tests_failed = 0;
  int ready_mode   = 0;
  int acc_cnt      = 0;
  int sop_cnt      = 0;
  int eop_cnt      = 0;
  int done_cnt     = 0;
  int issue_cnt    = 0;

  exp_t sb[$];

  pixel_buffer_reader_if #(.DW(DW), .AW(AW)) bus ();

  pixel_buffer_reader #(
    .H_RES(H_RES), .V_RES(V_RES), .DW(DW), .AW(AW), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .enable    (enable),
    .bus       (bus),
    .busy      (busy),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // RAM model: one-cycle read latency, contents equal to address.
  always @(posedge clk) begin
    if (bus.ram_chipselect && bus.ram_clken) bus.ram_readdata <= bus.ram_address[DW-1:0];
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic pushFrames(input int frames);
    exp_t e;
    for (int f = 0; f < frames; f++) begin
      for (int i = 0; i < NPIX; i++) begin
        e.data = DW'(i);
        e.sop  = (i == 0);
        e.eop  = (i == NPIX - 1);
        sb.push_back(e);
      end
    end
  endtask

  task automatic waitAccepted(input string name, input int target, input int budget);
    int n = 0;
    while (acc_cnt < target && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput({name, "_reach"}, int'(acc_cnt >= target), 1);
  endtask

  task automatic waitIdle(input string name, input int budget);
    int n = 0;
    while (busy && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput({name, "_idle"}, int'(busy), 0);
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "_st_valid"},  int'(bus.st_valid), 0);
    checkOutput({tag, "_st_data"},   int'(bus.st_data), 0);
    checkOutput({tag, "_st_sop"},    int'(bus.st_sop), 0);
    checkOutput({tag, "_st_eop"},    int'(bus.st_eop), 0);
    checkOutput({tag, "_cs"},        int'(bus.ram_chipselect), 0);
    checkOutput({tag, "_clken"},     int'(bus.ram_clken), 0);
    checkOutput({tag, "_addr"},      int'(bus.ram_address), 0);
    checkOutput({tag, "_write"},     int'(bus.ram_write), 0);
    checkOutput({tag, "_writedata"}, int'(bus.ram_writedata), 0);
    checkOutput({tag, "_busy"},      int'(busy), 0);
    checkOutput({tag, "_frame_done"}, int'(frame_done), 0);
  endtask

  // Runs one table entry: frames with the given ready pattern, enable dropped after drop_after accepted pixels.
  task automatic applyStimulus(input vec_t v);
    int acc0, sop0, eop0, done0, cs_idle;
    acc0 = acc_cnt; sop0 = sop_cnt; eop0 = eop_cnt; done0 = done_cnt;
    ready_mode = v.ready_mode;
    pushFrames(v.frames);
    enable = 1'b1;
    waitAccepted(v.name, acc0 + v.drop_after, 4000);
    enable = 1'b0;
    waitIdle(v.name, 4000);
    repeat (2) @(posedge clk);
    #1;
    cs_idle = 0;
    for (int i = 0; i < 8; i++) begin
      if (bus.ram_chipselect) cs_idle++;
      @(posedge clk); #1;
    end
    checkOutput({v.name, "_pixels"},   acc_cnt - acc0,   v.exp_pixels);
    checkOutput({v.name, "_sops"},     sop_cnt - sop0,   v.exp_sop);
    checkOutput({v.name, "_eops"},     eop_cnt - eop0,   v.exp_eop);
    checkOutput({v.name, "_done"},     done_cnt - done0, v.exp_done);
    checkOutput({v.name, "_sb_empty"}, sb.size(),        0);
    checkOutput({v.name, "_no_issue"}, cs_idle,          0);
    ready_mode = 0;
  endtask

  // Sink ready driver, updated shortly after each rising edge.
  initial begin
    bus.st_ready = 1'b0;
    forever begin
      @(posedge clk); #2;
      case (ready_mode)
        0:       bus.st_ready = 1'b1;
        1:       bus.st_ready = 1'b0;
        default: bus.st_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: scoreboard compare, hold stability, frame_done timing, address range.
  initial begin
    logic          hold_pending;
    logic          exp_done;
    logic [DW+1:0] hold_val;
    logic [DW+1:0] cur;
    exp_t          e;
    hold_pending = 1'b0;
    exp_done     = 1'b0;
    hold_val     = '0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        hold_pending = 1'b0;
        exp_done     = 1'b0;
      end else begin
        checkOutput("frame_done", int'(frame_done), int'(exp_done));
        exp_done = 1'b0;
        if (frame_done) done_cnt++;
        if (bus.ram_chipselect) begin
          issue_cnt++;
          checkOutput("addr_range", int'(bus.ram_address <= AW'(NPIX - 1)), 1);
          checkOutput("clken_eq_cs", int'(bus.ram_clken), 1);
          checkOutput("write_zero", int'(bus.ram_write), 0);
        end
        if (bus.st_valid) begin
          cur = {bus.st_data, bus.st_sop, bus.st_eop};
          if (hold_pending) checkOutput("hold_stable", int'(cur), int'(hold_val));
          if (bus.st_ready) begin
            if (sb.size() == 0) begin
              checkOutput("sb_has_entry", sb.size(), 1);
            end else begin
              e = sb.pop_front();
              checkOutput("pixel_data", int'(bus.st_data), int'(e.data));
              checkOutput("pixel_sop",  int'(bus.st_sop),  int'(e.sop));
              checkOutput("pixel_eop",  int'(bus.st_eop),  int'(e.eop));
            end
            acc_cnt++;
            if (bus.st_sop) sop_cnt++;
            if (bus.st_eop) begin
              eop_cnt++;
              exp_done = 1'b1;
            end
            hold_pending = 1'b0;
          end else begin
            hold_pending = 1'b1;
            hold_val     = cur;
          end
        end else if (hold_pending) begin
          checkOutput("valid_held", int'(bus.st_valid), 1);
          hold_pending = 1'b0;
        end
      end
    end
  end

  // Watchdog against a stuck run.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t vecs[4];
    vec_t after_reset;
    int   acc0, iss0, lat, first_cs, first_addr, cs_late;

    vecs[0] = '{"one_frame",   0, 1, 1,            NPIX,     1, 1, 1};
    vecs[1] = '{"two_frames",  0, 2, NPIX + 1,     2 * NPIX, 2, 2, 2};
    vecs[2] = '{"random_3f",   2, 3, 2 * NPIX + 1, 3 * NPIX, 3, 3, 3};
    vecs[3] = '{"drop_after5", 0, 1, 6,            NPIX,     1, 1, 1};
    after_reset = '{"after_reset", 0, 1, 1, NPIX, 1, 1, 1};

    reset_n = 1'b0;
    enable  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkReset("por");
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Latency from enable to first issue and first valid beat.
    acc0 = acc_cnt;
    ready_mode = 0;
    pushFrames(1);
    enable = 1'b1;
    lat = 0; first_cs = 0; first_addr = -1;
    while (!bus.st_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
      if (lat == 1) begin
        first_cs   = int'(bus.ram_chipselect);
        first_addr = int'(bus.ram_address);
      end
    end
    checkOutput("first_issue_cs",      first_cs,   1);
    checkOutput("first_issue_addr",    first_addr, 0);
    checkOutput("first_valid_latency", lat,        3);
    enable = 1'b0;
    waitIdle("latency", 200);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("latency_pixels",   acc_cnt - acc0, NPIX);
    checkOutput("latency_sb_empty", sb.size(),      0);

    for (int i = 0; i < 4; i++) applyStimulus(vecs[i]);

    // Sink stalled for 10 cycles mid-frame: FIFO fills, reads stop, stream resumes intact.
    acc0 = acc_cnt;
    iss0 = issue_cnt;
    ready_mode = 0;
    pushFrames(1);
    enable = 1'b1;
    waitAccepted("stall", acc0 + 3, 200);
    enable = 1'b0;
    ready_mode = 1;
    cs_late = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (i >= 5 && bus.ram_chipselect) cs_late++;
    end
    checkOutput("stall_fifo_full", (issue_cnt - iss0) - (acc_cnt - acc0), FIFO_DEPTH);
    checkOutput("stall_cs_quiet",  cs_late,                               0);
    checkOutput("stall_valid",     int'(bus.st_valid),                    1);
    ready_mode = 0;
    waitIdle("stall", 400);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("stall_pixels",   acc_cnt - acc0, NPIX);
    checkOutput("stall_sb_empty", sb.size(),      0);

    // Asynchronous reset after pixel 7, then a clean frame from pixel 0.
    acc0 = acc_cnt;
    pushFrames(1);
    enable = 1'b1;
    waitAccepted("midreset", acc0 + 8, 200);
    reset_n = 1'b0;
    enable  = 1'b0;
    #1;
    checkReset("midreset");
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    applyStimulus(after_reset);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
